// File: rtl/c_bus_writeback_if.sv
// Memory write bus between the writeback stage (master) and the C memory (slave).
// A transfer completes on the rising edge where mem_req_o && mem_ack_i.
interface c_bus_writeback_if #(
    parameter int ADDR_WIDTH      = 16,
    parameter int BUS_WIDTH_BYTES = 32
);
    logic                         mem_req_o;
    logic [ADDR_WIDTH-1:0]        mem_addr_o;
    logic [8*BUS_WIDTH_BYTES-1:0] mem_wdata_o;
    logic [BUS_WIDTH_BYTES-1:0]   mem_be_o;
    logic                         mem_ack_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_be_o,
        input  mem_ack_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_be_o,
        output mem_ack_i
    );
endinterface

// File: rtl/c_bus_writeback.sv
// Result-drain stage: packs a row-major element stream little-endian into bus
// words, queues them in a small FIFO and writes them out over a req/ack bus.
module c_bus_writeback #(
    parameter int DATA_WIDTH       = 8,
    parameter int DATA_WIDTH_BYTES = 1,
    parameter int BUS_WIDTH_BYTES  = 32,
    parameter int ADDR_WIDTH       = 16,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [15:0]           m_i,
    input  logic [15:0]           p_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic                  elem_valid_i,
    input  logic [DATA_WIDTH-1:0] elem_data_i,
    output logic                  elem_ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    c_bus_writeback_if.master     bus
);
    localparam int EPW      = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
    localparam int BUS_BITS = 8 * BUS_WIDTH_BYTES;
    localparam int LANE_W   = (EPW > 1) ? $clog2(EPW) : 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_reg, state_next;
    logic [31:0]           total_reg;
    logic [31:0]           elem_cnt_reg;
    logic [LANE_W-1:0]     lane_reg;
    logic [BUS_BITS-1:0]   pack_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;

    // Packed-word FIFO storage (no reset needed; outputs are gated by the count)
    logic [BUS_BITS-1:0]        data_mem [FIFO_DEPTH];
    logic [BUS_WIDTH_BYTES-1:0] be_mem   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]      addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]           count_reg;

    logic [31:0]                total_in;
    logic [ADDR_WIDTH-1:0]      aligned_base;
    logic [BUS_BITS-1:0]        word_next;
    logic [BUS_WIDTH_BYTES-1:0] be_next;
    logic                       fifo_full, fifo_empty;
    logic                       accept, last_elem, word_done, push, pop;

    assign total_in     = {16'd0, m_i} * {16'd0, p_i};
    assign aligned_base = base_addr_i & ~ADDR_WIDTH'(BUS_WIDTH_BYTES - 1);

    // Full is judged on the registered count so ack never reaches ready combinationally
    assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);

    assign elem_ready_o = (state_reg == RUN) && !fifo_full;
    assign accept       = elem_valid_i && elem_ready_o;
    assign last_elem    = (elem_cnt_reg == total_reg - 32'd1);
    assign word_done    = (lane_reg == LANE_W'(EPW - 1)) || last_elem;
    assign push         = accept && word_done;
    assign pop          = bus.mem_req_o && bus.mem_ack_i;

    assign busy_o = (state_reg != IDLE);
    assign done_o = (state_reg == DONE);

    // Bus side is presented straight from the FIFO head; zero when nothing is queued
    assign bus.mem_req_o   = !fifo_empty;
    assign bus.mem_addr_o  = fifo_empty ? '0 : addr_mem[rd_ptr_reg];
    assign bus.mem_wdata_o = fifo_empty ? '0 : data_mem[rd_ptr_reg];
    assign bus.mem_be_o    = fifo_empty ? '0 : be_mem[rd_ptr_reg];

    // Insert the incoming element into its lane of the word being packed
    generate
        for (genvar gi = 0; gi < EPW; gi++) begin : g_lane
            assign word_next[gi*DATA_WIDTH +: DATA_WIDTH] =
                (lane_reg == LANE_W'(gi)) ? elem_data_i : pack_reg[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Byte enables cover lanes 0..lane_reg; lane 0 is always filled when a word is pushed
    generate
        for (genvar gi = 0; gi < BUS_WIDTH_BYTES; gi++) begin : g_be
            if (gi < DATA_WIDTH_BYTES) begin : g_first
                assign be_next[gi] = 1'b1;
            end else begin : g_rest
                assign be_next[gi] = (lane_reg >= LANE_W'(gi / DATA_WIDTH_BYTES));
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_i) state_next = (total_in == 32'd0) ? DONE : RUN;
            RUN:     if (accept && last_elem) state_next = DRAIN;
            DRAIN:   if (fifo_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operation setup, element packing and FIFO pointer/count bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_reg    <= '0;
            elem_cnt_reg <= '0;
            lane_reg     <= '0;
            pack_reg     <= '0;
            addr_reg     <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (state_reg == IDLE && start_i) begin
                total_reg    <= total_in;
                addr_reg     <= aligned_base;
                elem_cnt_reg <= '0;
                lane_reg     <= '0;
                pack_reg     <= '0;
            end
            if (accept) begin
                elem_cnt_reg <= elem_cnt_reg + 32'd1;
                if (word_done) begin
                    lane_reg <= '0;
                    pack_reg <= '0;
                    addr_reg <= addr_reg + ADDR_WIDTH'(BUS_WIDTH_BYTES);
                end else begin
                    lane_reg <= lane_reg + LANE_W'(1);
                    pack_reg <= word_next;
                end
            end
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO write port: the completed word goes in on the edge its last lane is accepted
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= word_next;
            be_mem[wr_ptr_reg]   <= be_next;
            addr_mem[wr_ptr_reg] <= addr_reg;
        end
    end
endmodule

// File: tb/tb_c_bus_writeback.sv
// Directed bench for c_bus_writeback: element feeder, req/ack memory responder
// with programmable delay/stall, and per-case checks against a packing model.
module tb_c_bus_writeback;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [15:0] m_i, p_i, base_addr_i;
    logic        elem_valid_i;
    logic [7:0]  elem_data_i;
    logic        elem_ready_o, busy_o, done_o;

    c_bus_writeback_if #(.ADDR_WIDTH(16), .BUS_WIDTH_BYTES(32)) bus ();

    c_bus_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .m_i          (m_i),
        .p_i          (p_i),
        .base_addr_i  (base_addr_i),
        .elem_valid_i (elem_valid_i),
        .elem_data_i  (elem_data_i),
        .elem_ready_o (elem_ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          ack_delay = 1;
    bit          ack_block = 1'b0;
    logic [7:0]  seed      = 8'h00;
    int          done_cnt  = 0;
    int          wr_at_done = 0;
    bit          seen_req  = 1'b0;
    bit          seen_ready = 1'b0;
    logic [15:0]  wr_addr [$];
    logic [31:0]  wr_be   [$];
    logic [255:0] wr_data [$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] val(input int k);
        return 8'((k * 5) + int'(seed));
    endfunction

    function automatic logic [255:0] exp_data(input int total, input int w);
        logic [255:0] d = '0;
        for (int j = 0; j < 32; j++)
            if (w * 32 + j < total) d[j*8 +: 8] = val(w * 32 + j);
        return d;
    endfunction

    function automatic logic [31:0] exp_be(input int total, input int w);
        logic [31:0] b = '0;
        for (int j = 0; j < 32; j++)
            if (w * 32 + j < total) b[j] = 1'b1;
        return b;
    endfunction

    // Memory responder: acks after ack_delay cycles of request, logs each write as it is acked
    initial begin
        int cnt = 0;
        bus.mem_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.mem_ack_i = 1'b0;
                cnt = 0;
            end else if (bus.mem_ack_i) begin
                bus.mem_ack_i = 1'b0;
                cnt = 0;
            end else if (bus.mem_req_o && !ack_block) begin
                if (cnt >= ack_delay) begin
                    bus.mem_ack_i = 1'b1;
                    wr_addr.push_back(bus.mem_addr_o);
                    wr_be.push_back(bus.mem_be_o);
                    wr_data.push_back(bus.mem_wdata_o);
                    $display("write addr=%h be=%h data=%h", bus.mem_addr_o, bus.mem_be_o, bus.mem_wdata_o);
                end else begin
                    cnt++;
                end
            end
        end
    end

    // Output monitor
    initial begin
        forever begin
            @(negedge clk);
            if (done_o) begin
                done_cnt++;
                wr_at_done = wr_addr.size();
            end
            if (bus.mem_req_o) seen_req = 1'b1;
            if (elem_ready_o)  seen_ready = 1'b1;
        end
    end

    task automatic start_op(input logic [15:0] m, input logic [15:0] p, input logic [15:0] base);
        @(negedge clk);
        start_i = 1'b1; m_i = m; p_i = p; base_addr_i = base;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Offers elements first..last-1; gives up after stall_limit cycles without acceptance
    task automatic feed(input int first, input int last, input int stall_limit, output int next_idx);
        int idx = first;
        int idle = 0;
        while (idx < last && idle < stall_limit) begin
            elem_valid_i = 1'b1;
            elem_data_i  = val(idx);
            if (elem_ready_o) begin
                idx++;
                idle = 0;
            end else begin
                idle++;
            end
            @(negedge clk);
        end
        elem_valid_i = 1'b0;
        next_idx = idx;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 256'(done_cnt != d0), 256'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_be.delete();
        wr_data.delete();
    endtask

    task automatic run_case(input string tag, input logic [15:0] m, input logic [15:0] p,
                            input logic [15:0] base, input int delay, input logic [7:0] sd);
        int total = int'(m) * int'(p);
        int nw = (total + 31) / 32;
        int n, d0;
        logic [15:0] a;
        seed = sd;
        ack_delay = delay;
        clear_log();
        d0 = done_cnt;
        start_op(m, p, base);
        feed(0, total, 200, n);
        chk({tag, "_accepted"}, 256'(n), 256'(total));
        wait_done(tag, d0, 4000);
        chk({tag, "_done_once"}, 256'(done_cnt - d0), 256'(1));
        chk({tag, "_nwrites"}, 256'(wr_addr.size()), 256'(nw));
        chk({tag, "_writes_before_done"}, 256'(wr_at_done), 256'(nw));
        chk({tag, "_busy_after"}, 256'(busy_o), 256'(0));
        for (int i = 0; i < nw && i < wr_addr.size(); i++) begin
            a = 16'(int'(base & 16'hFFE0) + 32 * i);
            chk({tag, "_addr"}, 256'(wr_addr[i]), 256'(a));
            chk({tag, "_be"},   256'(wr_be[i]),   256'(exp_be(total, i)));
            chk({tag, "_data"}, wr_data[i],       exp_data(total, i));
        end
    endtask

    initial begin
        int n, d0;
        reset = 1'b1;
        start_i = 1'b0; m_i = '0; p_i = '0; base_addr_i = '0;
        elem_valid_i = 1'b0; elem_data_i = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_req",   256'(bus.mem_req_o),   256'(0));
        chk("rst_addr",  256'(bus.mem_addr_o),  256'(0));
        chk("rst_wdata", bus.mem_wdata_o,       256'(0));
        chk("rst_be",    256'(bus.mem_be_o),    256'(0));
        chk("rst_ready", 256'(elem_ready_o),    256'(0));
        chk("rst_busy",  256'(busy_o),          256'(0));
        chk("rst_done",  256'(done_o),          256'(0));

        // 4x4, one partial word
        run_case("c1", 16'd4, 16'd4, 16'h1000, 1, 8'h10);
        if (wr_addr.size() > 0) begin
            chk("c1_addr_lit", 256'(wr_addr[0]), 256'(16'h1000));
            chk("c1_be_lit",   256'(wr_be[0]),   256'(32'h0000FFFF));
        end

        // 8x8, slow ack, two full words
        run_case("c2", 16'd8, 16'd8, 16'h0400, 3, 8'h33);
        if (wr_be.size() > 1) chk("c2_be_lit", 256'(wr_be[1]), 256'(32'hFFFFFFFF));

        // Zero-size result: straight to done, no traffic
        seen_req = 1'b0; seen_ready = 1'b0; d0 = done_cnt;
        start_op(16'd0, 16'd5, 16'h2000);
        chk("c3_done_next", 256'(done_o), 256'(1));
        repeat (3) @(negedge clk);
        chk("c3_done_once",  256'(done_cnt - d0), 256'(1));
        chk("c3_no_req",     256'(seen_req),      256'(0));
        chk("c3_no_ready",   256'(seen_ready),    256'(0));
        chk("c3_busy_after", 256'(busy_o),        256'(0));

        // 16x16 with ack withheld: FIFO fills at 4 words, then drains
        seed = 8'h5A; ack_delay = 0; ack_block = 1'b1;
        clear_log(); d0 = done_cnt;
        start_op(16'd16, 16'd16, 16'h3000);
        feed(0, 256, 20, n);
        chk("c4_stall_count", 256'(n),            256'(128));
        chk("c4_stall_ready", 256'(elem_ready_o), 256'(0));
        chk("c4_stall_req",   256'(bus.mem_req_o), 256'(1));
        chk("c4_no_writes",   256'(wr_addr.size()), 256'(0));
        ack_block = 1'b0;
        feed(128, 256, 50, n);
        chk("c4_accepted", 256'(n), 256'(256));
        wait_done("c4", d0, 4000);
        chk("c4_nwrites", 256'(wr_addr.size()), 256'(8));
        if (wr_addr.size() == 8) begin
            chk("c4_last_addr", 256'(wr_addr[7]), 256'(16'h30E0));
            chk("c4_last_data", wr_data[7], exp_data(256, 7));
        end

        // Unaligned base and address wrap
        run_case("c5a", 16'd4, 16'd4, 16'h0013, 1, 8'h01);
        if (wr_addr.size() > 0) chk("c5a_addr_lit", 256'(wr_addr[0]), 256'(16'h0000));
        run_case("c5b", 16'd8, 16'd8, 16'hFFE0, 2, 8'h77);
        if (wr_addr.size() > 1) begin
            chk("c5b_addr0_lit", 256'(wr_addr[0]), 256'(16'hFFE0));
            chk("c5b_addr1_lit", 256'(wr_addr[1]), 256'(16'h0000));
        end

        // Reset in the middle of RUN with a word queued
        seed = 8'h20; ack_block = 1'b1; clear_log();
        start_op(16'd8, 16'd8, 16'h2000);
        feed(0, 40, 20, n);
        chk("c6_pre_req", 256'(bus.mem_req_o), 256'(1));
        d0 = done_cnt;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("c6_req",   256'(bus.mem_req_o),  256'(0));
        chk("c6_wdata", bus.mem_wdata_o,      256'(0));
        chk("c6_ready", 256'(elem_ready_o),   256'(0));
        chk("c6_busy",  256'(busy_o),         256'(0));
        chk("c6_done",  256'(done_o),         256'(0));
        @(negedge clk);
        reset = 1'b0;
        ack_block = 1'b0;
        repeat (10) @(negedge clk);
        chk("c6_no_done",   256'(done_cnt - d0),  256'(0));
        chk("c6_no_writes", 256'(wr_addr.size()), 256'(0));
        run_case("c6r", 16'd4, 16'd4, 16'h1000, 1, 8'h10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute watchdog
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
